// File: rtl/shift_seq_ctrl.sv
// Command sequencer for an 8-bit multi-mode shift register.
// cmd_* in, res_* out, sr_* drives the register, done_cnt counts results.
module shift_seq_ctrl #(
  parameter int AMT_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_in1,
  input  logic [AMT_W-1:0] cmd_amt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             busy,
  output logic             sr_en,
  output logic [2:0]       sr_ctrl,
  output logic [7:0]       sr_din,
  output logic             sr_in1,
  input  logic [7:0]       sr_dout,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       data_q, data_d;
  logic             in1_q, in1_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      in1_q   <= 1'b0;
      amt_q   <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      in1_q   <= in1_d;
      amt_q   <= amt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    in1_d     = in1_q;
    amt_d     = amt_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    res_data  = 8'h00;
    sr_en     = 1'b0;
    sr_ctrl   = 3'b000;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          in1_d   = cmd_in1;
          amt_d   = cmd_amt;
          cnt_d   = cmd_amt;
          state_d = (cmd_op == 3'b000) ? S_CLEAR : S_LOAD;
        end
      end
      S_CLEAR: begin
        sr_en   = 1'b1;
        sr_ctrl = 3'b000;
        state_d = S_DONE;
      end
      S_LOAD: begin
        sr_en   = 1'b1;
        sr_ctrl = 3'b001;
        if (op_q == 3'b001 || amt_q == '0)
          state_d = S_DONE;
        else
          state_d = S_SHIFT;
      end
      S_SHIFT: begin
        sr_en   = 1'b1;
        sr_ctrl = op_q;
        cnt_d   = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1))
          state_d = S_DONE;
      end
      S_DONE: begin
        // sr_en is low here, so dout is stable.
        res_valid = 1'b1;
        res_data  = sr_dout;
        if (res_ready) begin
          state_d = S_IDLE;
          if (done_q != '1)
            done_d = done_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign sr_din   = data_q;
  assign sr_in1   = in1_q;
  assign done_cnt = done_q;

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command sequencer for the 8-bit multi-mode shift register (clear/load/logical/rotate/fill-shift, 3-bit op code).
- Accepts one command per transaction over a valid/ready handshake: op, data, fill bit, shift amount.
- Drives the shift register's en/ctrl/din/in1 for as many cycles as the command needs.
- Returns the shift register's output on a valid/ready result port and counts completed commands.

Parameters:
AMT_W, 3, width of shift-amount field; amount range 0..2^AMT_W-1
CNT_W, 16, width of completed-command counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept command
cmd_op  in  3  shift-register op code (000 clear, 001 load, 010 lsr, 011 lsl, 100 ror, 101 rol, 110 fill-right, 111 fill-left)
cmd_data  in  8  value loaded before shifting
cmd_in1  in  1  fill bit for ops 110/111
cmd_amt  in  AMT_W  number of shift cycles
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  8  result value
busy  out  1  high in any state except IDLE
sr_en  out  1  to shift register en
sr_ctrl  out  3  to shift register ctrl
sr_din  out  8  to shift register din
sr_in1  out  1  to shift register in1
sr_dout  in  8  from shift register dout
done_cnt  out  CNT_W  completed commands, saturating

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; op/data/in1/amt registers=0; shift counter=0; done_cnt=0.
  - Outputs: sr_en=0, res_valid=0, res_data=0, busy=0, cmd_ready=1.
- States: IDLE, CLEAR, LOAD, SHIFT, DONE.
- Output decoding per state:
  - cmd_ready=1 only in IDLE.
  - sr_en=1 only in CLEAR, LOAD and SHIFT.
  - sr_ctrl: 000 in CLEAR, 001 in LOAD, latched op in SHIFT, 000 otherwise.
  - sr_din=latched data; sr_in1=latched in1 (both constant for the whole command).
- IDLE:
  - On cmd_valid&cmd_ready, latch op/data/in1/amt and load the shift counter with amt.
  - op=000 -> CLEAR; any other op -> LOAD.
- CLEAR: one cycle -> DONE.
- LOAD: one cycle. Next state:
  - op=001 -> DONE (amt ignored).
  - op>=010 with amt=0 -> DONE.
  - otherwise -> SHIFT.
- SHIFT: one shift per cycle; the counter decrements each cycle; leave to DONE in the cycle the counter equals 1. Exactly amt shift cycles are issued.
- DONE:
  - res_valid=1; res_data=sr_dout (combinational pass-through, stable because sr_en=0).
  - Outside DONE, res_data=0.
  - Hold until res_ready. On res_valid&res_ready: done_cnt increments, saturating at all-ones; next state IDLE.
- Latency, command accepted at cycle T:
  - Clear or load-only: res_valid at T+2.
  - Shift ops: res_valid at T+2+amt.
  - Minimum command-to-command spacing is latency+1 cycles: no accept occurs in the DONE handshake cycle.
- cmd_* inputs are ignored outside IDLE; a held cmd_valid is accepted on the next IDLE cycle.
- res_ready high while not in DONE has no effect.
- Reset mid-operation: immediate return to IDLE, sr_en=0, no result produced, done_cnt cleared. The shift register has no reset; its content is don't-care because every non-clear command reloads it first.

Test Plan:
- Reset release: cmd_ready=1, busy=0, res_valid=0, done_cnt=0. Then op=100, data=0x81, amt=1 -> res_data=0xC0, res_valid at T+3.
- op=101, data=0x81, amt=3 -> exactly 3 SHIFT cycles with sr_ctrl=101, res_data=0x0C. Same command with op=010, data=0xF0, amt=4 -> 0x0F.
- op=111, data=0x00, in1=1, amt=7 -> res_data=0x7F at T+9. op=001, data=0x5A, amt=5 -> 0x5A at T+2, no SHIFT cycles.
- op=000 after any load -> res_data=0x00 at T+2. op=011, amt=0, data=0x3C -> 0x3C at T+2.
- Back-pressure: res_ready low 5 cycles in DONE -> res_valid and res_data held, cmd_ready=0, a held cmd_valid is not accepted. Raise res_ready -> one done_cnt increment, next command accepted on the following cycle.
- Assert rst_n low asynchronously mid-SHIFT (op=010, amt=7, after 3 shifts) -> same-cycle IDLE outputs, sr_en=0, done_cnt=0. Next command (op=001, data=0xA5) returns 0xA5.
